// File: rtl/usb_pkg.sv
// Shared USB definitions for the audio OUT endpoint: token PIDs, endpoint
// range, byte-lane positions inside a stereo frame, and FSM state encoding.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  localparam int EP_MIN = 1;
  localparam int EP_MAX = 15;

  // Byte order inside one 32-bit stereo frame as it arrives on the bus.
  localparam logic [1:0] LANE_L_LO = 2'd0;
  localparam logic [1:0] LANE_L_HI = 2'd1;
  localparam logic [1:0] LANE_R_LO = 2'd2;
  localparam logic [1:0] LANE_R_HI = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } ep_state_t;

endpackage

// File: rtl/usb_audio_fifo_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
module usb_audio_fifo_ram #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [31:0]           rd_data
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Write one assembled frame
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; data holds until the next pull
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/usb_audio_out_endpoint.sv
// Isochronous audio OUT endpoint. Assembles 16-bit stereo PCM frames from
// host DATA packets, commits a packet to the frame FIFO only once it ended
// cleanly on a frame boundary, and hands one frame out per consumer pull.
// Optional build macro USB_AUDIO_OUT_STATS_EN adds PacketCount/DropCount.
module usb_audio_out_endpoint
  import usb_pkg::*;
#(
  parameter int ENDPOINT   = 1,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic                  Enable,
  input  logic [3:0]            Endpoint,
  input  logic                  Error,
  input  logic                  OUT_Setup,
  input  logic                  OUT_SoP,
  input  logic                  OUT_EoP,
  input  logic [7:0]            OUT_Data,
  input  logic                  OUT_Valid,
  output logic                  OUT_WaitRequest,
  output logic                  OUT_Isochronous,
  output logic                  OUT_Stall,
  input  logic                  Sample_Ready,
  output logic [15:0]           Sample_Left,
  output logic [15:0]           Sample_Right,
  output logic                  Sample_Valid,
  output logic [DEPTH_LOG2:0]   Level,
  output logic                  Overflow,
  output logic                  Underflow,
  input  logic                  ClearFlags
`ifdef USB_AUDIO_OUT_STATS_EN
  ,
  output logic [15:0]           PacketCount,
  output logic [15:0]           DropCount
`endif
);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  ep_state_t   state;
  logic [1:0]  lane;
  logic [23:0] frame_tmp;
  ptr_t        wr_tmp;
  ptr_t        wr_commit;
  ptr_t        rd;
  logic        error_q;
  logic        show_data;
  logic [31:0] ram_q;

  logic        hit;
  logic        byte_ok;
  logic        sop_ok;
  logic        eop_ok;
  logic        err_rise;
  logic        recv_byte;
  logic        frame_done;
  logic        full;
  logic        wr_en;
  logic [31:0] wr_data;
  ptr_t        wr_tmp_inc;
  ptr_t        wr_after;
  logic [1:0]  lane_after;
  ptr_t        fill;
  logic        pull_data;

  assign OUT_WaitRequest = 1'b0;
  assign OUT_Isochronous = 1'b1;
  assign OUT_Stall       = 1'b0;

  assign hit        = (Endpoint == 4'(ENDPOINT)) && !OUT_Setup && Enable;
  assign byte_ok    = OUT_Valid && hit;
  assign sop_ok     = byte_ok && OUT_SoP;
  assign eop_ok     = OUT_EoP && hit;
  assign err_rise   = Error && !error_q;
  assign recv_byte  = (state == ST_RECV) && byte_ok && !sop_ok && !err_rise;
  assign frame_done = recv_byte && (lane == LANE_R_HI);
  assign wr_tmp_inc = wr_tmp + 1'b1;
  assign full       = (wr_tmp_inc == rd);
  assign wr_en      = frame_done && !full;
  assign wr_data    = {OUT_Data, frame_tmp};
  assign lane_after = recv_byte ? lane + 2'd1 : lane;
  assign wr_after   = frame_done ? wr_tmp_inc : wr_tmp;

  // One slot is always kept free, so the N-bit difference never wraps
  assign fill      = wr_commit - rd;
  assign Level     = {1'b0, fill};
  assign pull_data = Sample_Ready && Enable && (fill != '0);

  assign Sample_Left  = show_data ? ram_q[15:0]  : 16'd0;
  assign Sample_Right = show_data ? ram_q[31:16] : 16'd0;

`ifdef USB_AUDIO_OUT_STATS_EN
  logic [15:0] pkt_base;
  logic [15:0] drop_base;
  assign pkt_base  = ClearFlags ? 16'd0 : PacketCount;
  assign drop_base = ClearFlags ? 16'd0 : DropCount;
`endif

  usb_audio_fifo_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (Clk),
    .wr_en  (wr_en),
    .wr_addr(wr_tmp),
    .wr_data(wr_data),
    .rd_en  (pull_data),
    .rd_addr(rd),
    .rd_data(ram_q)
  );

  // Packet FSM: stages bytes into frames, advances the tentative pointer,
  // commits or rolls back at packet end, and raises Overflow on a full FIFO
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= ST_IDLE;
      lane      <= LANE_L_LO;
      frame_tmp <= '0;
      wr_tmp    <= '0;
      wr_commit <= '0;
      error_q   <= 1'b0;
      Overflow  <= 1'b0;
`ifdef USB_AUDIO_OUT_STATS_EN
      PacketCount <= '0;
      DropCount   <= '0;
`endif
    end else begin
      error_q <= Error;
      if (ClearFlags) begin
        Overflow <= 1'b0;
`ifdef USB_AUDIO_OUT_STATS_EN
        PacketCount <= '0;
        DropCount   <= '0;
`endif
      end
      if (!Enable) begin
        state     <= ST_IDLE;
        lane      <= LANE_L_LO;
        wr_tmp    <= rd;
        wr_commit <= rd;
`ifdef USB_AUDIO_OUT_STATS_EN
        if (state != ST_IDLE) DropCount <= drop_base + 16'd1;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (sop_ok) begin
              frame_tmp[7:0] <= OUT_Data;
              lane           <= LANE_L_HI;
              wr_tmp         <= wr_commit;
              state          <= eop_ok ? ST_IDLE : ST_RECV;
`ifdef USB_AUDIO_OUT_STATS_EN
              if (eop_ok) DropCount <= drop_base + 16'd1;
`endif
            end
          end
          ST_RECV: begin
            if (err_rise) begin
              wr_tmp <= wr_commit;
              lane   <= LANE_L_LO;
              state  <= ST_IDLE;
`ifdef USB_AUDIO_OUT_STATS_EN
              DropCount <= drop_base + 16'd1;
`endif
            end else if (sop_ok) begin
              frame_tmp[7:0] <= OUT_Data;
              lane           <= LANE_L_HI;
              wr_tmp         <= wr_commit;
              state          <= eop_ok ? ST_IDLE : ST_RECV;
`ifdef USB_AUDIO_OUT_STATS_EN
              DropCount <= drop_base + (eop_ok ? 16'd2 : 16'd1);
`endif
            end else if (frame_done && full) begin
              Overflow <= 1'b1;
              wr_tmp   <= wr_commit;
              lane     <= LANE_L_LO;
              state    <= eop_ok ? ST_IDLE : ST_DROP;
`ifdef USB_AUDIO_OUT_STATS_EN
              if (eop_ok) DropCount <= drop_base + 16'd1;
`endif
            end else begin
              if (recv_byte) begin
                lane <= lane_after;
                case (lane)
                  LANE_L_LO: frame_tmp[7:0]   <= OUT_Data;
                  LANE_L_HI: frame_tmp[15:8]  <= OUT_Data;
                  LANE_R_LO: frame_tmp[23:16] <= OUT_Data;
                  default:   frame_tmp        <= frame_tmp;
                endcase
              end
              if (frame_done) wr_tmp <= wr_tmp_inc;
              if (eop_ok) begin
                state <= ST_IDLE;
                lane  <= LANE_L_LO;
                if ((lane_after == LANE_L_LO) && !Error) begin
                  wr_commit <= wr_after;
`ifdef USB_AUDIO_OUT_STATS_EN
                  PacketCount <= pkt_base + 16'd1;
`endif
                end else begin
                  wr_tmp <= wr_commit;
`ifdef USB_AUDIO_OUT_STATS_EN
                  DropCount <= drop_base + 16'd1;
`endif
                end
              end
            end
          end
          ST_DROP: begin
            if (err_rise || eop_ok) begin
              wr_tmp <= wr_commit;
              lane   <= LANE_L_LO;
              state  <= ST_IDLE;
`ifdef USB_AUDIO_OUT_STATS_EN
              DropCount <= drop_base + 16'd1;
`endif
            end else if (sop_ok) begin
              frame_tmp[7:0] <= OUT_Data;
              lane           <= LANE_L_HI;
              wr_tmp         <= wr_commit;
              state          <= ST_RECV;
`ifdef USB_AUDIO_OUT_STATS_EN
              DropCount <= drop_base + 16'd1;
`endif
            end
          end
          default: begin
            state <= ST_IDLE;
            lane  <= LANE_L_LO;
          end
        endcase
      end
    end
  end

  // Consumer side: pull advances the read pointer, an empty or disabled
  // pull yields a zero frame, and only an enabled empty pull is an Underflow
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      rd           <= '0;
      show_data    <= 1'b0;
      Sample_Valid <= 1'b0;
      Underflow    <= 1'b0;
    end else begin
      Sample_Valid <= Sample_Ready;
      if (ClearFlags) Underflow <= 1'b0;
      if (Sample_Ready) begin
        if (pull_data) begin
          rd        <= rd + 1'b1;
          show_data <= 1'b1;
        end else begin
          show_data <= 1'b0;
          if (Enable) Underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_audio_out_endpoint.sv
// Testbench for usb_audio_out_endpoint: directed packets with a scoreboard
// of expected stereo frames popped by an independent sample monitor.
`timescale 1ns/1ps
module tb_usb_audio_out_endpoint;

  localparam int DEPTH_LOG2 = 2;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        Enable = 1'b0;
  logic [3:0]  Endpoint = 4'd1;
  logic        Error = 1'b0;
  logic        OUT_Setup = 1'b0;
  logic        OUT_SoP = 1'b0;
  logic        OUT_EoP = 1'b0;
  logic [7:0]  OUT_Data = 8'd0;
  logic        OUT_Valid = 1'b0;
  logic        OUT_WaitRequest;
  logic        OUT_Isochronous;
  logic        OUT_Stall;
  logic        Sample_Ready = 1'b0;
  logic [15:0] Sample_Left;
  logic [15:0] Sample_Right;
  logic        Sample_Valid;
  logic [DEPTH_LOG2:0] Level;
  logic        Overflow;
  logic        Underflow;
  logic        ClearFlags = 1'b0;
`ifdef USB_AUDIO_OUT_STATS_EN
  logic [15:0] PacketCount;
  logic [15:0] DropCount;
`endif

  int n_vectors = 0;
  int n_miscompares = 0;
  int exp_pkt = 0;
  int exp_drop = 0;
  logic [31:0] exp_q[$];

  usb_audio_out_endpoint #(
    .ENDPOINT(1),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .Clk(Clk),
    .nReset(nReset),
    .Enable(Enable),
    .Endpoint(Endpoint),
    .Error(Error),
    .OUT_Setup(OUT_Setup),
    .OUT_SoP(OUT_SoP),
    .OUT_EoP(OUT_EoP),
    .OUT_Data(OUT_Data),
    .OUT_Valid(OUT_Valid),
    .OUT_WaitRequest(OUT_WaitRequest),
    .OUT_Isochronous(OUT_Isochronous),
    .OUT_Stall(OUT_Stall),
    .Sample_Ready(Sample_Ready),
    .Sample_Left(Sample_Left),
    .Sample_Right(Sample_Right),
    .Sample_Valid(Sample_Valid),
    .Level(Level),
    .Overflow(Overflow),
    .Underflow(Underflow),
    .ClearFlags(ClearFlags)
`ifdef USB_AUDIO_OUT_STATS_EN
    ,
    .PacketCount(PacketCount),
    .DropCount(DropCount)
`endif
  );

  always #10 Clk = ~Clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Sample monitor: every Sample_Valid pulse must match the oldest expected frame
  initial begin
    forever begin
      @(negedge Clk);
      if (Sample_Valid) begin
        if (exp_q.size() == 0) begin
          n_vectors++;
          n_miscompares++;
          $display("[TB] FAIL unexpected_sample: got L=0x%0h R=0x%0h, expected no sample", Sample_Left, Sample_Right);
        end else begin
          check_output("sample", {Sample_Right, Sample_Left}, exp_q.pop_front());
        end
      end
    end
  end

  // Watchdog so a stuck run still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sop);
    OUT_Valid = 1'b1;
    OUT_Data  = d;
    OUT_SoP   = sop;
    tick();
    OUT_Valid = 1'b0;
    OUT_SoP   = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic first);
    send_byte(l[7:0], first);
    send_byte(l[15:8], 1'b0);
    send_byte(r[7:0], 1'b0);
    send_byte(r[15:8], 1'b0);
  endtask

  task automatic send_eop();
    OUT_EoP = 1'b1;
    tick();
    OUT_EoP = 1'b0;
  endtask

  task automatic pull(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back({r, l});
    Sample_Ready = 1'b1;
    tick();
    Sample_Ready = 1'b0;
    tick();
  endtask

  task automatic clear_flags();
    ClearFlags = 1'b1;
    tick();
    ClearFlags = 1'b0;
    exp_pkt  = 0;
    exp_drop = 0;
  endtask

  task automatic apply_reset();
    nReset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    nReset = 1'b1;
    exp_pkt  = 0;
    exp_drop = 0;
    tick();
  endtask

  task automatic check_stats();
`ifdef USB_AUDIO_OUT_STATS_EN
    check_output("packet_count", 32'(PacketCount), 32'(exp_pkt));
    check_output("drop_count", 32'(DropCount), 32'(exp_drop));
`endif
  endtask

  initial begin
    Enable = 1'b1;
    apply_reset();

    $display("[TB] reset state");
    check_output("reset_level", 32'(Level), 32'd0);
    check_output("reset_overflow", 32'(Overflow), 32'd0);
    check_output("reset_underflow", 32'(Underflow), 32'd0);
    check_output("reset_valid", 32'(Sample_Valid), 32'd0);
    check_output("reset_samples", {Sample_Right, Sample_Left}, 32'd0);
    check_output("const_outputs", {29'd0, OUT_WaitRequest, OUT_Isochronous, OUT_Stall}, 32'b010);
    check_stats();

    $display("[TB] two-frame packet");
    send_frame(16'h0001, 16'h0002, 1'b1);
    send_frame(16'h0003, 16'h0004, 1'b0);
    send_eop();
    exp_pkt++;
    check_output("level_after_commit", 32'(Level), 32'd2);
    pull(16'h0001, 16'h0002);
    pull(16'h0003, 16'h0004);
    check_output("level_after_pulls", 32'(Level), 32'd0);

    $display("[TB] six-byte packet rolls back");
    send_frame(16'h1111, 16'h2222, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_eop();
    exp_drop++;
    check_output("level_partial", 32'(Level), 32'd0);

    $display("[TB] error mid-packet then good packet");
    send_frame(16'h5151, 16'h5252, 1'b1);
    send_frame(16'h5353, 16'h5454, 1'b0);
    Error = 1'b1;
    tick();
    Error = 1'b0;
    tick();
    exp_drop++;
    check_output("level_after_error", 32'(Level), 32'd0);
    send_frame(16'h1234, 16'h5678, 1'b1);
    send_eop();
    exp_pkt++;
    check_output("level_good_after_error", 32'(Level), 32'd1);
    pull(16'h1234, 16'h5678);
    check_stats();

    $display("[TB] overflow on empty fifo");
    send_frame(16'hA001, 16'hB001, 1'b1);
    send_frame(16'hA002, 16'hB002, 1'b0);
    send_frame(16'hA003, 16'hB003, 1'b0);
    send_frame(16'hA004, 16'hB004, 1'b0);
    check_output("overflow_set", 32'(Overflow), 32'd1);
    send_eop();
    exp_drop++;
    check_output("level_overflow", 32'(Level), 32'd0);
    check_stats();
    clear_flags();
    check_output("overflow_cleared", 32'(Overflow), 32'd0);

    $display("[TB] overflow keeps earlier data");
    send_frame(16'hBEEF, 16'hCAFE, 1'b1);
    send_eop();
    exp_pkt++;
    send_frame(16'hC001, 16'hD001, 1'b1);
    send_frame(16'hC002, 16'hD002, 1'b0);
    send_frame(16'hC003, 16'hD003, 1'b0);
    send_eop();
    exp_drop++;
    check_output("overflow_again", 32'(Overflow), 32'd1);
    check_output("level_kept", 32'(Level), 32'd1);
    check_stats();
    pull(16'hBEEF, 16'hCAFE);

    $display("[TB] underflow");
    pull(16'h0000, 16'h0000);
    check_output("underflow_set", 32'(Underflow), 32'd1);
    clear_flags();
    check_output("underflow_cleared", 32'(Underflow), 32'd0);
    check_output("overflow_cleared_too", 32'(Overflow), 32'd0);
    exp_q.push_back(32'd0);
    Sample_Ready = 1'b1;
    ClearFlags   = 1'b1;
    tick();
    Sample_Ready = 1'b0;
    ClearFlags   = 1'b0;
    exp_pkt  = 0;
    exp_drop = 0;
    tick();
    check_output("underflow_wins_clear", 32'(Underflow), 32'd1);
    clear_flags();

    $display("[TB] foreign endpoint and setup ignored");
    Endpoint = 4'd2;
    send_frame(16'h7777, 16'h8888, 1'b1);
    send_eop();
    Endpoint = 4'd1;
    check_output("level_other_ep", 32'(Level), 32'd0);
    OUT_Setup = 1'b1;
    send_frame(16'h9999, 16'hAAAA, 1'b1);
    send_eop();
    OUT_Setup = 1'b0;
    check_output("level_setup", 32'(Level), 32'd0);
    check_stats();

    $display("[TB] disable flushes");
    send_frame(16'h0BAD, 16'hF00D, 1'b1);
    send_eop();
    exp_pkt++;
    check_output("level_before_disable", 32'(Level), 32'd1);
    Enable = 1'b0;
    tick();
    check_output("level_flushed", 32'(Level), 32'd0);
    pull(16'h0000, 16'h0000);
    check_output("no_underflow_disabled", 32'(Underflow), 32'd0);
    Enable = 1'b1;
    tick();

    $display("[TB] reset mid-packet");
    send_frame(16'h4242, 16'h4343, 1'b1);
    send_eop();
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b0);
    apply_reset();
    check_output("level_after_reset", 32'(Level), 32'd0);
    check_output("samples_after_reset", {Sample_Right, Sample_Left}, 32'd0);
    check_output("flags_after_reset", {30'd0, Overflow, Underflow}, 32'd0);
    check_stats();

    $display("[TB] commit and pull together");
    send_frame(16'h0101, 16'h0202, 1'b1);
    send_eop();
    exp_pkt++;
    send_frame(16'h0303, 16'h0404, 1'b1);
    exp_q.push_back({16'h0202, 16'h0101});
    OUT_EoP      = 1'b1;
    Sample_Ready = 1'b1;
    tick();
    OUT_EoP      = 1'b0;
    Sample_Ready = 1'b0;
    exp_pkt++;
    check_output("level_commit_pull", 32'(Level), 32'd1);
    tick();
    pull(16'h0303, 16'h0404);
    check_output("level_final", 32'(Level), 32'd0);
    check_stats();

    repeat (3) tick();
    check_output("pending_samples", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
